// File: rtl/set_bank_if.sv
// Bus-side signal bundle for the settings bank: bus-cycle inputs from the
// bus-cycle controller and the committed settings / timeout status returned.
interface set_bank_if #(
    parameter int NDEV = 6,
    parameter int TW   = 4,
    parameter int AW   = TW + NDEV + 1
);
    logic            BACT;
    logic [AW-1:0]   A;
    logic            SetCSWR;
    logic [NDEV-1:0] DevSel;
    logic [NDEV-1:0] SlowDev;
    logic            SlowClockGate;
    logic [TW-1:0]   SlowTimeout;
    logic            SetPending;
    logic            SlowActive;
    logic            SlowExpired;

    // Bus side: drives the cycle, observes settings and timeout status.
    modport master (
        output BACT, A, SetCSWR, DevSel,
        input  SlowDev, SlowClockGate, SlowTimeout, SetPending, SlowActive, SlowExpired
    );

    // Settings bank side.
    modport slave (
        input  BACT, A, SetCSWR, DevSel,
        output SlowDev, SlowClockGate, SlowTimeout, SetPending, SlowActive, SlowExpired
    );
endinterface

// File: rtl/set_bank.sv
// Slow-device settings bank. A settings write seen during a bus cycle is
// staged and only committed once the cycle has ended, so the slow enables,
// clock gate and timeout never change under a running access. A per-access
// counter flags slow accesses that outlast the committed timeout.
module set_bank #(
    parameter int NDEV = 6,
    parameter int TW   = 4
) (
    input  logic     CLK,
    input  logic     POR,
    set_bank_if.slave bus
);
    localparam int AW = TW + NDEV + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    // Registered bus qualifiers
    logic bact_reg;
    logic wr_reg;
    logic wr1_reg;

    // Staging and committed settings
    logic [AW-1:0]   stage_reg;
    logic            pending_reg;
    logic [NDEV-1:0] slow_dev_reg;
    logic            clock_gate_reg;
    logic [TW-1:0]   timeout_reg;

    // Timeout FSM
    state_t          state_reg, state_next;
    logic [TW-1:0]   cnt_reg, cnt_next;

    logic            write_event;
    logic            commit;
    logic            access_start;
    logic [NDEV-1:0] dev_hit;
    logic            slow_hit;

    // One write event per rising edge of the qualified write strobe; a commit
    // needs the bus to have been seen idle, so the two never coincide.
    assign write_event  = wr_reg & ~wr1_reg;
    assign commit       = pending_reg & ~bact_reg;
    assign access_start = bus.BACT & ~bact_reg;

    // Per-device slow match; any selected slow device makes the access slow,
    // which also covers a non-one-hot select.
    generate
        for (genvar gi = 0; gi < NDEV; gi++) begin : g_hit
            assign dev_hit[gi] = bus.DevSel[gi] & slow_dev_reg[gi];
        end
    endgenerate
    assign slow_hit = |dev_hit;

    // Register the bus-active and write-select inputs for edge detection.
    always_ff @(posedge CLK) begin
        if (POR) begin
            bact_reg <= 1'b0;
            wr_reg   <= 1'b0;
            wr1_reg  <= 1'b0;
        end else begin
            bact_reg <= bus.BACT;
            wr_reg   <= bus.BACT & bus.SetCSWR;
            wr1_reg  <= wr_reg;
        end
    end

    // Stage the latest write (last write wins) and track whether one awaits commit.
    always_ff @(posedge CLK) begin
        if (POR) begin
            stage_reg   <= '0;
            pending_reg <= 1'b0;
        end else if (write_event) begin
            stage_reg   <= bus.A;
            pending_reg <= 1'b1;
        end else if (commit) begin
            pending_reg <= 1'b0;
        end
    end

    // Commit the staged fields once the bus has gone idle.
    always_ff @(posedge CLK) begin
        if (POR) begin
            slow_dev_reg   <= '1;
            clock_gate_reg <= 1'b0;
            timeout_reg    <= '1;
        end else if (commit) begin
            timeout_reg    <= stage_reg[AW-1:NDEV+1];
            slow_dev_reg   <= stage_reg[NDEV:1];
            clock_gate_reg <= stage_reg[0];
        end
    end

    // Timeout FSM state and counter registers.
    always_ff @(posedge CLK) begin
        if (POR) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Timeout FSM next state; bus going idle always wins over expiry.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (access_start && slow_hit) begin
                    cnt_next   = timeout_reg;
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (!bus.BACT) begin
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = EXPIRED;
                end else begin
                    cnt_next = cnt_reg - TW'(1);
                end
            end
            EXPIRED: begin
                if (!bus.BACT) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.SlowDev       = slow_dev_reg;
    assign bus.SlowClockGate = clock_gate_reg;
    assign bus.SlowTimeout   = timeout_reg;
    assign bus.SetPending    = pending_reg;
    assign bus.SlowActive    = (state_reg == COUNT);
    assign bus.SlowExpired   = (state_reg == EXPIRED);

endmodule

// File: tb/tb_set_bank.sv
// Directed bench for set_bank: staging/commit timing, last-write-wins,
// timeout expiry, fast and short accesses, and reset during a count.
module tb_set_bank;
    logic clk;
    logic por;
    int   n_cmp;
    int   n_err;

    set_bank_if #(.NDEV(6), .TW(4)) bus ();

    set_bank #(.NDEV(6), .TW(4)) dut (
        .CLK (clk),
        .POR (por),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled and inputs driven 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write bus cycle followed by the idle cycles needed to commit it.
    task automatic do_write(input logic [10:0] a);
        bus.BACT    = 1'b1;
        bus.SetCSWR = 1'b1;
        bus.A       = a;
        bus.DevSel  = 6'b0;
        repeat (3) tick();
        bus.BACT    = 1'b0;
        bus.SetCSWR = 1'b0;
        repeat (2) tick();
        $display("write cycle A=%h committed", a);
    endtask

    task automatic test_reset();
        por = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (bus.SlowDev !== 6'h3F) begin
            n_err++; $display("FAIL reset_slowdev got=%h want=3f", bus.SlowDev);
        end
        n_cmp++;
        if (bus.SlowTimeout !== 4'hF) begin
            n_err++; $display("FAIL reset_timeout got=%h want=f", bus.SlowTimeout);
        end
        n_cmp++;
        if (bus.SlowClockGate !== 1'b0) begin
            n_err++; $display("FAIL reset_gate got=%b want=0", bus.SlowClockGate);
        end
        n_cmp++;
        if (bus.SetPending !== 1'b0) begin
            n_err++; $display("FAIL reset_pending got=%b want=0", bus.SetPending);
        end
        n_cmp++;
        if ({bus.SlowActive, bus.SlowExpired} !== 2'b00) begin
            n_err++; $display("FAIL reset_fsm got=%b%b want=00", bus.SlowActive, bus.SlowExpired);
        end
        por = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_staged_write();
        bus.BACT    = 1'b1;
        bus.SetCSWR = 1'b1;
        bus.A       = {4'h3, 6'b000101, 1'b1};
        tick();
        n_cmp++;
        if (bus.SetPending !== 1'b0) begin
            n_err++; $display("FAIL stage_early_pending got=%b want=0", bus.SetPending);
        end
        for (int i = 2; i <= 5; i++) begin
            tick();
            n_cmp++;
            if (bus.SetPending !== 1'b1) begin
                n_err++; $display("FAIL stage_pending cyc=%0d got=%b want=1", i, bus.SetPending);
            end
            n_cmp++;
            if ({bus.SlowTimeout, bus.SlowDev, bus.SlowClockGate} !== {4'hF, 6'h3F, 1'b0}) begin
                n_err++; $display("FAIL stage_hold cyc=%0d got=%h/%h/%b want=f/3f/0",
                                  i, bus.SlowTimeout, bus.SlowDev, bus.SlowClockGate);
            end
        end
        bus.BACT    = 1'b0;
        bus.SetCSWR = 1'b0;
        tick();
        n_cmp++;
        if ({bus.SetPending, bus.SlowTimeout} !== {1'b1, 4'hF}) begin
            n_err++; $display("FAIL stage_one_after got=%b/%h want=1/f", bus.SetPending, bus.SlowTimeout);
        end
        tick();
        n_cmp++;
        if ({bus.SlowTimeout, bus.SlowDev, bus.SlowClockGate, bus.SetPending} !==
            {4'h3, 6'b000101, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL stage_commit got=%h/%b/%b/%b want=3/000101/1/0",
                              bus.SlowTimeout, bus.SlowDev, bus.SlowClockGate, bus.SetPending);
        end
        $display("staged write checked");
    endtask

    task automatic test_last_write_wins();
        bus.BACT    = 1'b1;
        bus.SetCSWR = 1'b1;
        bus.A       = {4'h9, 6'b110000, 1'b0};
        repeat (3) tick();
        bus.SetCSWR = 1'b0;
        repeat (2) tick();
        // Second write in a new cycle with no BACT-low gap in between.
        bus.SetCSWR = 1'b1;
        bus.A       = {4'h7, 6'b000100, 1'b1};
        repeat (3) tick();
        n_cmp++;
        if ({bus.SetPending, bus.SlowTimeout, bus.SlowDev} !== {1'b1, 4'h3, 6'b000101}) begin
            n_err++; $display("FAIL lww_no_early_commit got=%b/%h/%b want=1/3/000101",
                              bus.SetPending, bus.SlowTimeout, bus.SlowDev);
        end
        bus.BACT    = 1'b0;
        bus.SetCSWR = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({bus.SlowTimeout, bus.SlowDev, bus.SlowClockGate, bus.SetPending} !==
            {4'h7, 6'b000100, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL lww_commit got=%h/%b/%b/%b want=7/000100/1/0",
                              bus.SlowTimeout, bus.SlowDev, bus.SlowClockGate, bus.SetPending);
        end
        $display("last write wins checked");
    endtask

    task automatic test_expiry();
        do_write({4'h3, 6'b000100, 1'b0});
        bus.DevSel = 6'b000100;
        bus.BACT   = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_cmp++;
            if ({bus.SlowActive, bus.SlowExpired} !== {(i <= 4), (i >= 5)}) begin
                n_err++; $display("FAIL expiry cyc=%0d got=%b%b want=%b%b", i,
                                  bus.SlowActive, bus.SlowExpired, (i <= 4), (i >= 5));
            end
        end
        bus.BACT   = 1'b0;
        bus.DevSel = 6'b0;
        tick();
        n_cmp++;
        if ({bus.SlowActive, bus.SlowExpired} !== 2'b00) begin
            n_err++; $display("FAIL expiry_release got=%b%b want=00", bus.SlowActive, bus.SlowExpired);
        end
        $display("expiry checked");
    endtask

    task automatic test_fast_short();
        bus.DevSel = 6'b000010;
        bus.BACT   = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++;
            if (bus.SlowActive !== 1'b0) begin
                n_err++; $display("FAIL fast_access cyc=%0d got=%b want=0", i, bus.SlowActive);
            end
        end
        bus.BACT   = 1'b0;
        bus.DevSel = 6'b0;
        tick();
        do_write({4'h5, 6'b000100, 1'b0});
        bus.DevSel = 6'b000100;
        bus.BACT   = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_cmp++;
            if ({bus.SlowActive, bus.SlowExpired} !== 2'b10) begin
                n_err++; $display("FAIL short_count cyc=%0d got=%b%b want=10", i,
                                  bus.SlowActive, bus.SlowExpired);
            end
        end
        bus.BACT   = 1'b0;
        bus.DevSel = 6'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_cmp++;
            if ({bus.SlowActive, bus.SlowExpired} !== 2'b00) begin
                n_err++; $display("FAIL short_idle cyc=%0d got=%b%b want=00", i,
                                  bus.SlowActive, bus.SlowExpired);
            end
        end
        $display("fast and short accesses checked");
    endtask

    // Non-one-hot select plus a write staged mid-access: the count must use
    // the committed timeout 5, and the staged timeout 1 lands afterwards.
    task automatic test_committed_timeout();
        bus.DevSel  = 6'b000110;
        bus.BACT    = 1'b1;
        bus.SetCSWR = 1'b1;
        bus.A       = {4'h1, 6'b000100, 1'b0};
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_cmp++;
            if ({bus.SlowActive, bus.SlowExpired} !== {(i <= 6), (i >= 7)}) begin
                n_err++; $display("FAIL committed_count cyc=%0d got=%b%b want=%b%b", i,
                                  bus.SlowActive, bus.SlowExpired, (i <= 6), (i >= 7));
            end
        end
        bus.BACT    = 1'b0;
        bus.SetCSWR = 1'b0;
        bus.DevSel  = 6'b0;
        repeat (2) tick();
        n_cmp++;
        if ({bus.SlowTimeout, bus.SetPending, bus.SlowExpired} !== {4'h1, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL committed_after got=%h/%b/%b want=1/0/0",
                              bus.SlowTimeout, bus.SetPending, bus.SlowExpired);
        end
        $display("committed timeout checked");
    endtask

    task automatic test_reset_mid_count();
        do_write({4'h4, 6'b001000, 1'b1});
        bus.DevSel = 6'b001000;
        bus.BACT   = 1'b1;
        tick();
        n_cmp++;
        if (bus.SlowActive !== 1'b1) begin
            n_err++; $display("FAIL midrst_started got=%b want=1", bus.SlowActive);
        end
        por      = 1'b1;
        bus.BACT = 1'b0;
        tick();
        n_cmp++;
        if ({bus.SlowActive, bus.SlowExpired} !== 2'b00) begin
            n_err++; $display("FAIL midrst_fsm got=%b%b want=00", bus.SlowActive, bus.SlowExpired);
        end
        n_cmp++;
        if ({bus.SlowTimeout, bus.SlowDev, bus.SlowClockGate, bus.SetPending} !=
            {4'hF, 6'h3F, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL midrst_settings got=%h/%h/%b/%b want=f/3f/0/0",
                              bus.SlowTimeout, bus.SlowDev, bus.SlowClockGate, bus.SetPending);
        end
        por        = 1'b0;
        bus.DevSel = 6'b0;
        tick();
        $display("reset mid-count checked");
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        por         = 1'b1;
        bus.BACT    = 1'b0;
        bus.SetCSWR = 1'b0;
        bus.A       = '0;
        bus.DevSel  = '0;
        test_reset();
        test_staged_write();
        test_last_write_wins();
        test_expiry();
        test_fast_short();
        test_committed_timeout();
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety bound so the run always ends even if the stimulus stalls.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end
endmodule
